// File: rtl/fb_kbd_ctrl_pkg.sv
// Shared types and constants for the PS/2 keyboard controller.
package fb_kbd_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } kbd_state_e;

    // Status word bit positions
    localparam int unsigned StatAv     = 0;
    localparam int unsigned StatOvf    = 1;
    localparam int unsigned StatPerr   = 2;
    localparam int unsigned StatCntLsb = 4;

    // True when data bits plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/fb_kbd_ctrl_if.sv
// CPU-side load-path port of the keyboard controller.
interface fb_kbd_ctrl_if;
    logic        rd_en;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        irq;

    modport master (output rd_en, output rd_sel, input rd_data, input irq);
    modport slave  (input rd_en, input rd_sel, output rd_data, output irq);
endinterface

// File: rtl/fb_kbd_fifo.sv
// Synchronous scan-code FIFO; a push while full is accepted only if a pop happens the same cycle.
module fb_kbd_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          wr, rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr && !rd) begin
                count_q <= count_q + CW'(1);
            end else if (rd && !wr) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fb_kbd_ctrl.sv
// PS/2 keyboard controller: synchroniser, receive FSM, sticky flags and CPU read mux.
// Define FB_KBD_PARITY_EN to enable odd-parity checking and the perr status flag.
module fb_kbd_ctrl
    import fb_kbd_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    fb_kbd_ctrl_if.slave  bus
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYC);

    logic          pclk_s1_q, pclk_s2_q, pclk_s3_q;
    logic          pdat_s1_q, pdat_s2_q;
    logic          strike, data_s;

    kbd_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [TW-1:0] tmo_q;
    logic          push_q;

    logic [7:0]    head;
    logic          full, empty, pop, ovf_evt, st_rd;
    logic [CW-1:0] count;
    logic          ovf_q, irq_q, perr_bit;
    logic [31:0]   rd_data_q, status;

    // Sync flops idle high so reset release never looks like a clock fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s1_q <= 1'b1;
            pclk_s2_q <= 1'b1;
            pclk_s3_q <= 1'b1;
            pdat_s1_q <= 1'b1;
            pdat_s2_q <= 1'b1;
        end else begin
            pclk_s1_q <= ps2_clk;
            pclk_s2_q <= pclk_s1_q;
            pclk_s3_q <= pclk_s2_q;
            pdat_s1_q <= ps2_data;
            pdat_s2_q <= pdat_s1_q;
        end
    end

    assign strike = pclk_s3_q && !pclk_s2_q;
    assign data_s = pdat_s2_q;

`ifdef FB_KBD_PARITY_EN
    logic par_q, perr_evt_q, perr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            push_q     <= 1'b0;
`ifdef FB_KBD_PARITY_EN
            par_q      <= 1'b0;
            perr_evt_q <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
`ifdef FB_KBD_PARITY_EN
            perr_evt_q <= 1'b0;
`endif
            if (state_q == StIdle || strike) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (strike && !data_s) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                    end
                end
                StData: begin
                    if (strike) begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                end
                StParity: begin
                    if (strike) begin
`ifdef FB_KBD_PARITY_EN
                        par_q <= data_s;
`endif
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (strike) begin
                        state_q <= StIdle;
                        if (data_s) begin
`ifdef FB_KBD_PARITY_EN
                            if (odd_parity_ok(shift_q, par_q)) begin
                                push_q <= 1'b1;
                            end else begin
                                perr_evt_q <= 1'b1;
                            end
`else
                            push_q <= 1'b1;
`endif
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
            // A stalled frame is abandoned; the partial byte is never pushed
            if (state_q != StIdle && !strike && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_q <= StIdle;
            end
        end
    end

    assign pop     = bus.rd_en && bus.rd_sel && !empty;
    assign st_rd   = bus.rd_en && !bus.rd_sel;
    assign ovf_evt = push_q && full && !pop;

    fb_kbd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef FB_KBD_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (st_rd) begin
            perr_q <= perr_evt_q;
        end else begin
            perr_q <= perr_q | perr_evt_q;
        end
    end
    assign perr_bit = perr_q;
`else
    assign perr_bit = 1'b0;
`endif

    always_comb begin
        status                     = '0;
        status[StatAv]             = !empty;
        status[StatOvf]            = ovf_q;
        status[StatPerr]           = perr_bit;
        status[StatCntLsb +: 4]    = 4'(count);
    end

    // A flag event coinciding with the status read survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            irq_q <= !empty;
            if (st_rd) begin
                ovf_q <= ovf_evt;
            end else begin
                ovf_q <= ovf_q | ovf_evt;
            end
            if (bus.rd_en) begin
                if (bus.rd_sel) begin
                    rd_data_q <= empty ? 32'h0 : {24'h0, head};
                end else begin
                    rd_data_q <= status;
                end
            end
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_fb_kbd_ctrl.sv
// Self-checking bench for fb_kbd_ctrl: PS/2 frame driver plus data-byte scoreboard.
module tb_fb_kbd_ctrl;

    logic clk;
    logic rst_n;
    logic ps2_clk;
    logic ps2_data;

    fb_kbd_ctrl_if bus ();

    fb_kbd_ctrl #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (4096)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [7:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_data(input string tag);
        logic [31:0] exp;
        bus.rd_sel = 1'b1;
        bus.rd_en  = 1'b1;
        tick(1);
        bus.rd_en  = 1'b0;
        exp = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp);
        bus.rd_sel = 1'b0;
        bus.rd_en  = 1'b1;
        tick(1);
        bus.rd_en  = 1'b0;
        chk(tag, bus.rd_data, exp);
    endtask

    // Sends the first nbits of start/data/parity/stop; pop_at_stop lands a data read
    // on the same cycle the FIFO push for this frame happens.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit pop_at_stop);
        logic [10:0] f;
        logic        p;
        bit          accept;
        p = bad_par ? (^b) : ~(^b);
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(10);
            ps2_clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                tick(3);
                read_data("pop_with_push");
                tick(6);
            end else begin
                tick(10);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(10);
`ifdef FB_KBD_PARITY_EN
        accept = (nbits == 11) && !bad_par;
`else
        accept = (nbits == 11);
`endif
        if (accept && exp_q.size() < 4) begin
            exp_q.push_back(b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        bus.rd_en   = 1'b0;
        bus.rd_sel  = 1'b0;
        tick(3);
        chk("reset_rd_data", bus.rd_data, 32'h0);
        chk("reset_irq", 32'(bus.irq), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // Single frame, irq, and flag clear
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        chk("t1_irq_high", 32'(bus.irq), 32'h1);
        read_status("t1_status", 32'h0000_0011);
        tick(2);
        chk("t1_status_hold", bus.rd_data, 32'h0000_0011);
        read_data("t1_data");
        tick(2);
        chk("t1_irq_low", 32'(bus.irq), 32'h0);
        read_status("t1_status_empty", 32'h0);

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 11, 1'b0);
        end
        read_status("t2_status_ovf", 32'h0000_0043);
        for (int i = 0; i < 4; i++) begin
            read_data("t2_data");
        end
        read_status("t2_status_clr", 32'h0);

        // Bad parity
        send_frame(8'h5A, 1'b1, 11, 1'b0);
`ifdef FB_KBD_PARITY_EN
        chk("t3_irq", 32'(bus.irq), 32'h0);
        read_status("t3_status_perr", 32'h0000_0004);
        read_status("t3_status_clr", 32'h0);
`else
        chk("t3_irq", 32'(bus.irq), 32'h1);
        read_status("t3_status", 32'h0000_0011);
        read_data("t3_data");
`endif

        // Aborted frame recovered by timeout
        send_frame(8'hA5, 1'b0, 5, 1'b0);
        tick(4200);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        read_status("t4_status", 32'h0000_0011);
        read_data("t4_data");

        // Push and pop in the same cycle while full
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b0, 11, 1'b0);
        end
        read_status("t5_status_full", 32'h0000_0041);
        send_frame(8'h05, 1'b0, 11, 1'b1);
        read_status("t5_status_after", 32'h0000_0041);
        for (int i = 0; i < 4; i++) begin
            read_data("t5_data");
        end
        read_status("t5_status_empty", 32'h0);

        // Empty read, then reset mid-frame
        read_data("t6_empty_data");
        read_status("t6_empty_status", 32'h0);
        send_frame(8'h77, 1'b0, 11, 1'b0);
        read_status("t6_pre_reset", 32'h0000_0011);
        send_frame(8'h3C, 1'b0, 6, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        tick(1);
        chk("t6_reset_rd_data", bus.rd_data, 32'h0);
        chk("t6_reset_irq", 32'(bus.irq), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        read_status("t6_post_reset", 32'h0);
        send_frame(8'h3C, 1'b0, 11, 1'b0);
        read_status("t6_status", 32'h0000_0011);
        read_data("t6_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
